// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte (e.g. 0xF4 enable reporting, 0xFF reset) to a PS/2
// mouse or keyboard over the shared open-drain clock/data pair. The sequence is:
// hold the clock low (inhibit), pull data low (start bit), release the clock,
// then shift 8 data bits LSB first, odd parity and a released stop bit on
// device-generated falling edges. Finally sample the device ACK and wait for
// both lines to go idle.
//
// Ports:
//   CLOCK       in   system clock (50 MHz nominal)
//   reset       in   asynchronous active-high reset
//   tx_data     in   [7:0] command byte
//   tx_valid    in   request to send tx_data (ignored unless tx_ready)
//   tx_ready    out  idle and able to accept a byte
//   done        out  one-cycle pulse when a transfer ends (ok or error)
//   err         out  one-cycle pulse with done on NACK or timeout
//   rx_inhibit  out  high whenever the transmitter is not idle
//   ps2ck_in    in   raw PS/2 clock line
//   ps2dt_in    in   raw PS/2 data line
//   ps2ck_oe    out  1 pulls the PS/2 clock low (registered)
//   ps2dt_oe    out  1 pulls the PS/2 data low (registered)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 6000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       done,
  output logic       err,
  output logic       rx_inhibit,
  input  logic       ps2ck_in,
  input  logic       ps2dt_in,
  output logic       ps2ck_oe,
  output logic       ps2dt_oe
);

  // One shared counter times inhibit, setup and the transfer timeout.
  localparam int CNT_MAX_A = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INHIBIT = 3'd1,
    SETUP   = 3'd2,
    SHIFT   = 3'd3,
    ACK     = 3'd4,
    RELEASE = 3'd5
  } state_t;

  state_t        state_reg,  state_next;
  logic [CW-1:0] cnt_reg,    cnt_next;
  logic [3:0]    bitcnt_reg, bitcnt_next;
  logic [7:0]    shreg_reg,  shreg_next;
  logic          par_reg,    par_next;
  logic          nack_reg,   nack_next;
  logic          ck_oe_reg,  ck_oe_next;
  logic          dt_oe_reg,  dt_oe_next;
  logic          done_reg,   done_next;
  logic          err_reg,    err_next;
  logic          timeout;

  // ---------------------------------------------------------------------------
  // Input conditioning: index 0 = clock line, index 1 = data line.
  // Synchronizers reset to 1 so an idle (pulled-up) bus never looks like a fall.
  // ---------------------------------------------------------------------------
  logic [1:0] pin_in;
  logic [1:0] sync_reg [2];
  logic       ck_s;
  logic       dt_s;
  logic       ck_prev_reg;
  logic       fall_reg;

  assign pin_in = {ps2dt_in, ps2ck_in};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_sync
      always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
          sync_reg[gi] <= 2'b11;
        end else begin
          sync_reg[gi] <= {sync_reg[gi][0], pin_in[gi]};
        end
      end
    end
  endgenerate

  assign ck_s = sync_reg[0][1];
  assign dt_s = sync_reg[1][1];

  // Registered falling-edge detect: pin change -> fall_reg high 3 cycles later.
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      ck_prev_reg <= 1'b1;
      fall_reg    <= 1'b0;
    end else begin
      ck_prev_reg <= ck_s;
      fall_reg    <= ~ck_s & ck_prev_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      bitcnt_reg <= '0;
      shreg_reg  <= '0;
      par_reg    <= 1'b0;
      nack_reg   <= 1'b0;
      ck_oe_reg  <= 1'b0;
      dt_oe_reg  <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bitcnt_reg <= bitcnt_next;
      shreg_reg  <= shreg_next;
      par_reg    <= par_next;
      nack_reg   <= nack_next;
      ck_oe_reg  <= ck_oe_next;
      dt_oe_reg  <= dt_oe_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
    end
  end

  // tx_ready stays low during the done cycle so a new byte is accepted at the
  // earliest on the cycle after done.
  assign tx_ready   = (state_reg == IDLE) && !done_reg;
  assign rx_inhibit = (state_reg != IDLE);
  assign done       = done_reg;
  assign err        = err_reg;
  assign ps2ck_oe   = ck_oe_reg;
  assign ps2dt_oe   = dt_oe_reg;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bitcnt_next = bitcnt_reg;
    shreg_next  = shreg_reg;
    par_next    = par_reg;
    nack_next   = nack_reg;
    ck_oe_next  = ck_oe_reg;
    dt_oe_next  = dt_oe_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
    timeout     = (state_reg inside {SHIFT, ACK, RELEASE}) &&
                  (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

    case (state_reg)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          shreg_next = tx_data;
          par_next   = ~^tx_data;
          ck_oe_next = 1'b1;
          cnt_next   = '0;
          state_next = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_reg == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_next   = '0;
          dt_oe_next = 1'b1;          // start bit
          state_next = SETUP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      SETUP: begin
        if (cnt_reg == CW'(SETUP_CYCLES - 1)) begin
          ck_oe_next  = 1'b0;         // hand the clock to the device
          cnt_next    = '0;           // timeout window starts here
          bitcnt_next = '0;
          state_next  = SHIFT;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      SHIFT: begin
        cnt_next = cnt_reg + CW'(1);
        if (fall_reg) begin
          bitcnt_next = bitcnt_reg + 4'd1;
          if (bitcnt_reg < 4'd8) begin
            dt_oe_next = ~shreg_reg[bitcnt_reg[2:0]];
          end else if (bitcnt_reg == 4'd8) begin
            dt_oe_next = ~par_reg;
          end else begin
            dt_oe_next = 1'b0;        // stop bit: line released high
            state_next = ACK;
          end
        end
      end
      ACK: begin
        cnt_next = cnt_reg + CW'(1);
        if (fall_reg) begin
          nack_next  = dt_s;
          state_next = RELEASE;
        end
      end
      RELEASE: begin
        cnt_next = cnt_reg + CW'(1);
        if (ck_s && dt_s) begin
          done_next  = 1'b1;
          err_next   = nack_reg;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Timeout overrides anything decided above, including a final edge.
    if (timeout) begin
      ck_oe_next = 1'b0;
      dt_oe_next = 1'b0;
      done_next  = 1'b1;
      err_next   = 1'b1;
      state_next = IDLE;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Testbench for ps2_host_tx: an open-drain bus with a device model that
// clocks bits in, and a scoreboard monitor that checks each done/err pulse.
module tb_ps2_host_tx;

  localparam int INH = 200;
  localparam int SET = 20;
  localparam int TMO = 3000;
  localparam int H   = 40;   // device half clock period in system cycles

  logic       CLOCK = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready, done, err, rx_inhibit, ps2ck_oe, ps2dt_oe;
  logic       dev_ck_low = 1'b0;
  logic       dev_dt_low = 1'b0;
  logic       ps2ck, ps2dt;

  assign ps2ck = ~(ps2ck_oe | dev_ck_low);
  assign ps2dt = ~(ps2dt_oe | dev_dt_low);

  always #5 CLOCK = ~CLOCK;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .CLOCK     (CLOCK),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .done      (done),
    .err       (err),
    .rx_inhibit(rx_inhibit),
    .ps2ck_in  (ps2ck),
    .ps2dt_in  (ps2dt),
    .ps2ck_oe  (ps2ck_oe),
    .ps2dt_oe  (ps2dt_oe)
  );

  typedef struct {
    logic [7:0] data;
    logic       err;
    logic       chk;   // compare the device-captured frame
  } exp_t;

  exp_t       sb_q[$];
  logic [9:0] cap_bits = '0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         post_chk = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops one expectation per done pulse.
  always @(negedge CLOCK) begin
    exp_t e;
    if (post_chk) begin
      post_chk = 1'b0;
      check("ready_after_done", tx_ready, 1);
      check("ck_oe_after_done", ps2ck_oe, 0);
      check("dt_oe_after_done", ps2dt_oe, 0);
    end
    if (err && !done) check("err_without_done", err, 0);
    if (done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", done, 0);
      end else begin
        e = sb_q.pop_front();
        check("err", err, e.err);
        check("ready_low_in_done", tx_ready, 0);
        if (e.chk) begin
          check("byte", cap_bits[7:0], e.data);
          check("parity", cap_bits[8], ~^e.data);
          check("stop", cap_bits[9], 1);
        end
        $display("done: data %02h err %0d", e.data, err);
        post_chk = 1'b1;
      end
    end
  end

  // Issue a byte and measure the inhibit and setup phases.
  task automatic send(input logic [7:0] b, input bit exp_err, input bit chk, input bit push);
    exp_t e;
    int   n;
    @(negedge CLOCK);
    check("ready_before", tx_ready, 1);
    tx_data  = b;
    tx_valid = 1'b1;
    if (push) begin
      e.data = b; e.err = exp_err; e.chk = chk;
      sb_q.push_back(e);
    end
    @(posedge CLOCK); #1;
    check("ready_fall", tx_ready, 0);
    check("ck_oe_rise", ps2ck_oe, 1);
    check("rx_inhibit", rx_inhibit, 1);
    tx_valid = 1'b0;
    n = 0;
    while (!ps2dt_oe && n < INH + 100) begin @(posedge CLOCK); #1; n++; end
    check("inhibit_len", n, INH);
    check("ck_low_at_start", ps2ck_oe, 1);
    n = 0;
    while (ps2ck_oe && n < SET + 100) begin @(posedge CLOCK); #1; n++; end
    check("setup_len", n, SET);
    $display("send %02h: inhibit %0d setup %0d", b, INH, n);
  endtask

  // Device: generate n_edges data falls, sampling on each rising edge, then
  // optionally an ack edge (ack_low=1 pulls data low for ACK).
  task automatic device_xfer(input int n_edges, input bit do_ack, input bit ack_low);
    logic [9:0] bits;
    bits = '0;
    repeat (H) @(negedge CLOCK);
    for (int i = 0; i < n_edges; i++) begin
      if (i == 0) check("start_bit", ps2dt, 0);
      dev_ck_low = 1'b1;
      repeat (H) @(negedge CLOCK);
      bits[i] = ps2dt;
      dev_ck_low = 1'b0;
      repeat (H) @(negedge CLOCK);
    end
    cap_bits = bits;
    if (do_ack) begin
      dev_dt_low = ack_low;
      repeat (5) @(negedge CLOCK);
      dev_ck_low = 1'b1;
      repeat (H) @(negedge CLOCK);
      dev_ck_low = 1'b0;
      repeat (H) @(negedge CLOCK);
      dev_dt_low = 1'b0;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin @(negedge CLOCK); n++; end
    check("done_seen", sb_q.size(), 0);
    repeat (3) @(negedge CLOCK);
  endtask

  initial begin
    repeat (80000) @(posedge CLOCK);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge CLOCK);
    reset = 1'b0;
    @(negedge CLOCK);
    check("rst_ready", tx_ready, 1);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_inhibit", rx_inhibit, 0);
    check("rst_ck_oe", ps2ck_oe, 0);
    check("rst_dt_oe", ps2dt_oe, 0);

    // 0xF4 with ACK
    send(8'hF4, 1'b0, 1'b1, 1'b1);
    device_xfer(10, 1'b1, 1'b1);
    wait_idle(500);

    // 0xFF with ACK (parity 1)
    send(8'hFF, 1'b0, 1'b1, 1'b1);
    device_xfer(10, 1'b1, 1'b1);
    wait_idle(500);

    // 0x00 with NACK (data left high at ack edge)
    send(8'h00, 1'b1, 1'b1, 1'b1);
    device_xfer(10, 1'b1, 1'b0);
    wait_idle(500);

    // Device never clocks: timeout exactly TMO cycles after clock release
    send(8'h5A, 1'b1, 1'b0, 1'b1);
    n = 0;
    while (!done && n < TMO + 100) begin @(posedge CLOCK); #1; n++; end
    check("timeout_len", n, TMO);
    wait_idle(100);

    // 0xAA request during SHIFT of 0xF4 is ignored
    send(8'hF4, 1'b0, 1'b1, 1'b1);
    fork
      device_xfer(10, 1'b1, 1'b1);
      begin
        repeat (300) @(negedge CLOCK);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge CLOCK);
        check("aa_ready_low", tx_ready, 0);
        tx_valid = 1'b0;
      end
    join
    wait_idle(500);
    repeat (20) @(negedge CLOCK);
    check("aa_not_latched", ps2ck_oe, 0);

    // Reset at bitcnt 4 releases lines asynchronously, no done
    send(8'hF4, 1'b0, 1'b1, 1'b0);
    device_xfer(4, 1'b0, 1'b0);
    @(negedge CLOCK);
    reset = 1'b1;
    #1;
    check("rst_mid_ck_oe", ps2ck_oe, 0);
    check("rst_mid_dt_oe", ps2dt_oe, 0);
    repeat (3) @(negedge CLOCK);
    reset = 1'b0;
    @(negedge CLOCK);
    check("rst_mid_ready", tx_ready, 1);
    check("rst_mid_inhibit", rx_inhibit, 0);
    $display("reset mid-transfer at bitcnt 4");
    repeat (100) @(negedge CLOCK);

    // Following 0xF4 completes normally
    send(8'hF4, 1'b0, 1'b1, 1'b1);
    device_xfer(10, 1'b1, 1'b1);
    wait_idle(500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte, such as 0xF4 (enable data reporting) or 0xFF (reset), to the mouse or keyboard on the shared PS/2 pair. It is the outbound counterpart of the existing receive-only `ps2Mouse`/`ps2Keyboard` blocks. The top level instantiates it beside the receiver on the same `ps2ck`/`ps2dt` lines and gates the receiver with `rx_inhibit` while a command is in flight.

## Interface
Parameters:
- `INHIBIT_CYCLES`, default 6000: clock-low inhibit time (120 µs at 50 MHz).
- `SETUP_CYCLES`, default 50: data-low hold before the clock is released.
- `TIMEOUT_CYCLES`, default 1000000: limit from request to ack (20 ms).

Ports (clock and reset first):
- `CLOCK`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-high.
- `tx_data`, in, 8: command byte.
- `tx_valid`, in, 1: request to send `tx_data`.
- `tx_ready`, out, 1: idle and able to accept a byte.
- `done`, out, 1: one-cycle pulse when the transfer ends, with or without error.
- `err`, out, 1: one-cycle pulse coincident with `done`, on NACK or timeout.
- `rx_inhibit`, out, 1: high whenever the block is not idle.
- `ps2ck_in`, in, 1: sampled PS/2 clock line.
- `ps2dt_in`, in, 1: sampled PS/2 data line.
- `ps2ck_oe`, out, 1: 1 pulls the clock low; the top level drives `1'bz` otherwise.
- `ps2dt_oe`, out, 1: 1 pulls the data line low.

## Operation
- Input conditioning:
  - `ps2ck_in` and `ps2dt_in` each pass through a 2-flop synchronizer.
  - A clock falling edge (`fall`) is registered when the synchronized clock is 0 and its previous value was 1.
- Accept: when `tx_valid && tx_ready`, latch `tx_data` into `shreg` and compute `par = ~^tx_data` (odd parity). `tx_valid` is ignored while `tx_ready` is 0.
- States:
  - IDLE: `tx_ready`=1, both oe=0. On accept, go to INHIBIT.
  - INHIBIT: `ps2ck_oe`=1 for INHIBIT_CYCLES, then go to SETUP.
  - SETUP: `ps2dt_oe`=1 (start bit) and `ps2ck_oe`=1 for SETUP_CYCLES. Then set `ps2ck_oe`=0, clear the timeout counter, `bitcnt`=0, and go to SHIFT.
  - SHIFT: on each `fall`:
    - `bitcnt` 0–7: drive data bit `bitcnt`, LSB first (`ps2dt_oe` = ~bit).
    - `bitcnt` 8: drive `par`.
    - `bitcnt` 9: `ps2dt_oe`=0 (stop bit released).
    - `bitcnt` increments on each `fall`; after `bitcnt` 9, go to ACK.
  - ACK: on the next `fall`, sample synchronized data. 0 means ACK; 1 means NACK. Go to RELEASE.
  - RELEASE: wait until synchronized clock and data are both 1, then pulse `done` (and `err` if NACK) and go to IDLE.
- Timeout: the counter runs in SHIFT, ACK and RELEASE. When it reaches TIMEOUT_CYCLES:
  - both oe drop to 0;
  - `done`=1 and `err`=1;
  - the state returns to IDLE.
- `rx_inhibit` = (state != IDLE).
- `ps2ck_oe` and `ps2dt_oe` are registered outputs; they are never derived combinationally from inputs.

## Timing
- Reset values: both oe=0 (lines released), `tx_ready`=1, `done`=0, `err`=0, `rx_inhibit`=0, state IDLE.
- Reset asserted mid-transfer releases both lines asynchronously. The transfer is abandoned, with no `done` pulse.
- `tx_ready` falls the cycle after accept.
- `ps2ck_oe` rises the cycle after accept.
- `tx_ready` rises the cycle after the `done` pulse.
- Edge latency: a line change reaches `fall` 3 CLOCK cycles after the pin changes. The data update follows on the next edge.
  - This is well inside the ≥5 µs clock-low phase, so the data is stable before the device samples on the rising edge.
- Phase durations:
  - INHIBIT lasts exactly INHIBIT_CYCLES cycles.
  - SETUP lasts exactly SETUP_CYCLES cycles.
  - Start bit to clock release overlap: SETUP_CYCLES.
- Exactly 11 device falling edges complete a transfer: 10 data/parity/stop plus 1 ack.
- Extra falling edges seen in RELEASE are ignored.
- A timeout and a final edge in the same cycle: the timeout wins (`err`=1).
- Back-to-back sends: the earliest re-accept is the cycle after `done`.

## Test plan
- Byte 0xF4 with an ACKing device model (clock period 80 µs):
  - bits sampled on device rising edges: 0,0,1,0,1,1,1,1;
  - parity 0, stop 1;
  - device drives ACK low → `done`=1, `err`=0;
  - `tx_ready` returns to 1.
- Byte 0xFF:
  - parity bit sampled as 1;
  - clock held low ≥ INHIBIT_CYCLES before the data line falls.
- Byte 0x00 with the device leaving data high at the ack edge:
  - parity sampled as 1;
  - `done`=1 and `err`=1 together, for one cycle.
- Device never clocks:
  - after TIMEOUT_CYCLES, `done`/`err` pulse;
  - both oe=0, `tx_ready`=1.
- Protocol edge cases:
  - `tx_valid` pulsed with 0xAA during SHIFT of 0xF4 → ignored, 0xF4 bits unchanged.
  - `reset` at `bitcnt`=4 → both oe=0 the same cycle, `tx_ready`=1, no `done`.
  - A following 0xF4 send completes normally.
